// File: rtl/fast_msg_encoder.sv
// rtl/fast_msg_encoder.sv - FAST transmit encoder: COPY dictionary, pmap build, stop-bit byte serializer
module fast_msg_encoder #(
    parameter int beat_width       = 64,
    parameter int num_templates    = 4,
    parameter int max_message_size = 10,
    localparam int TW = (num_templates > 1) ? $clog2(num_templates) : 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [TW-1:0]         in_tid,
    input  logic [beat_width-1:0] in_value,
    input  logic                  in_copy,
    input  logic                  in_last,
    input  logic                  dict_clear,
    output logic [7:0]            out_byte,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  err_overflow
);
    localparam int NG  = (beat_width + 6) / 7;
    localparam int PW  = 7 * ((max_message_size + 7) / 7);
    localparam int NPB = PW / 7;
    localparam int BW  = $clog2(((NG > NPB) ? NG : NPB) + 1);
    localparam int IW  = $clog2(max_message_size + 1);
    localparam int DN  = num_templates * max_message_size;

    typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_PMAP, S_TID, S_FIELD} state_t;

    state_t                r_state, w_state_nxt;
    logic [TW-1:0]         r_tid;
    logic [IW-1:0]         r_idx, r_nstore, r_ncopy, r_fptr, w_fptr_nxt;
    logic [BW-1:0]         r_bidx, w_bidx_nxt;
    logic [PW-1:0]         r_pmap;
    logic [DN-1:0]         r_dvld;
    logic [beat_width-1:0] r_fields [max_message_size];
    logic [beat_width-1:0] r_dict   [DN];
    logic                  r_err;

    logic                  w_acc, w_first, w_drop, w_hit, w_dv, w_store, w_cbit;
    logic [TW-1:0]         w_tid;
    logic [IW-1:0]         w_idx, w_nstore_base, w_ncopy_base;
    logic [PW-1:0]         w_pmap_base;
    int                    w_dsel;
    logic [beat_width-1:0] w_val;
    logic [BW-1:0]         w_nb, w_npb;
    logic                  w_stop, w_pstop;

    // Minimal number of 7-bit groups needed; zero still takes one group.
    function automatic logic [BW-1:0] f_ngroups(input logic [beat_width-1:0] v);
        f_ngroups = BW'(1);
        for (int g = 1; g < NG; g++)
            if ((v >> (7 * g)) != '0) f_ngroups = BW'(g + 1);
    endfunction

    function automatic logic [6:0] f_group(input logic [beat_width-1:0] v,
                                           input logic [BW-1:0] n, input logic [BW-1:0] b);
        int sh;
        sh = 7 * (int'(n) - 1 - int'(b));
        return 7'(v >> sh);
    endfunction

    assign in_ready     = (r_state == S_IDLE) || (r_state == S_COLLECT);
    assign err_overflow = r_err;
    assign w_acc        = in_valid && in_ready;
    assign w_first      = (r_state == S_IDLE);
    assign w_tid        = w_first ? in_tid : r_tid;
    assign w_idx        = w_first ? '0 : r_idx;
    assign w_drop       = (w_idx >= IW'(max_message_size));
    assign w_nstore_base = w_first ? '0 : r_nstore;
    assign w_ncopy_base  = w_first ? '0 : r_ncopy;
    assign w_pmap_base   = w_first ? {1'b1, {(PW-1){1'b0}}} : r_pmap;

    always_comb begin
        w_dsel = int'(w_tid) * max_message_size + (w_drop ? 0 : int'(w_idx));
    end

    // A same-cycle dict_clear in IDLE must already hide the old entry from the compare.
    assign w_dv    = r_dvld[w_dsel] && !(w_first && dict_clear);
    assign w_hit   = in_copy && !w_drop && w_dv && (r_dict[w_dsel] == in_value);
    assign w_store = !w_drop && !w_hit;
    assign w_cbit  = !w_drop && in_copy;

    assign w_val   = (r_state == S_FIELD) ? r_fields[r_fptr] : beat_width'(r_tid);
    assign w_nb    = f_ngroups(w_val);
    assign w_stop  = (r_bidx == w_nb - BW'(1));
    assign w_npb   = BW'((int'(r_ncopy) + 7) / 7);
    assign w_pstop = (r_bidx == w_npb - BW'(1));

    always_comb begin
        w_state_nxt = r_state;
        w_bidx_nxt  = r_bidx;
        w_fptr_nxt  = r_fptr;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        out_byte    = 8'h00;
        case (r_state)
            S_IDLE: begin
                if (w_acc) w_state_nxt = in_last ? S_PMAP : S_COLLECT;
            end
            S_COLLECT: begin
                if (w_acc && in_last) w_state_nxt = S_PMAP;
            end
            S_PMAP: begin
                out_valid = 1'b1;
                out_byte  = {w_pstop, 7'(r_pmap >> (PW - 7 - 7 * int'(r_bidx)))};
                if (out_ready) begin
                    if (w_pstop) begin
                        w_bidx_nxt  = '0;
                        w_state_nxt = S_TID;
                    end else begin
                        w_bidx_nxt = r_bidx + BW'(1);
                    end
                end
            end
            S_TID, S_FIELD: begin
                out_valid = 1'b1;
                out_byte  = {w_stop, f_group(w_val, w_nb, r_bidx)};
                if (r_state == S_TID) out_last = w_stop && (r_nstore == '0);
                else                  out_last = w_stop && (r_fptr == r_nstore - IW'(1));
                if (out_ready) begin
                    if (!w_stop) begin
                        w_bidx_nxt = r_bidx + BW'(1);
                    end else begin
                        w_bidx_nxt = '0;
                        if (out_last) begin
                            w_state_nxt = S_IDLE;
                            w_fptr_nxt  = '0;
                        end else if (r_state == S_TID) begin
                            w_state_nxt = S_FIELD;
                        end else begin
                            w_fptr_nxt = r_fptr + IW'(1);
                        end
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= S_IDLE;
            r_tid    <= '0;
            r_idx    <= '0;
            r_nstore <= '0;
            r_ncopy  <= '0;
            r_pmap   <= '0;
            r_bidx   <= '0;
            r_fptr   <= '0;
            r_err    <= 1'b0;
            r_dvld   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_bidx  <= w_bidx_nxt;
            r_fptr  <= w_fptr_nxt;
            r_err   <= w_acc && w_drop;
            if (w_first && dict_clear) r_dvld <= '0;
            if (w_acc) begin
                r_tid    <= w_tid;
                r_idx    <= w_drop ? w_idx : w_idx + IW'(1);
                r_nstore <= w_nstore_base + (w_store ? IW'(1) : IW'(0));
                r_ncopy  <= w_ncopy_base + (w_cbit ? IW'(1) : IW'(0));
                r_pmap   <= w_pmap_base |
                            ((w_cbit && !w_hit) ? (PW'(1) << (PW - 2 - int'(w_ncopy_base))) : '0);
                if (w_cbit && !w_hit) r_dvld[w_dsel] <= 1'b1;
            end
        end
    end

    // Payload storage needs no reset: occupancy and valid bits gate every read.
    always_ff @(posedge clk) begin
        if (w_acc && w_store) r_fields[w_nstore_base] <= in_value;
        if (w_acc && w_cbit && !w_hit) r_dict[w_dsel] <= in_value;
    end
endmodule

// File: tb/tb_fast_msg_encoder.sv
// tb/tb_fast_msg_encoder.sv - directed self-checking bench for fast_msg_encoder
module tb_fast_msg_encoder;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_tid = 2'd0;
    logic [63:0] in_value = 64'd0;
    logic        in_copy = 1'b0;
    logic        in_last = 1'b0;
    logic        dict_clear = 1'b0;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_last;
    logic        err_overflow;

    int          checks = 0;
    int          errors = 0;
    int          n_busy = 0;
    int          n_err = 0;
    int          n_unstable = 0;
    bit          tog = 1'b0;
    bit          stalled = 1'b0;
    logic [7:0]  held = 8'h00;
    logic [63:0] m_val [$];
    bit          m_copy [$];
    logic [7:0]  exp_q [$];
    logic [7:0]  rx_b [$];
    bit          rx_l [$];

    fast_msg_encoder dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_tid(in_tid),
        .in_value(in_value), .in_copy(in_copy), .in_last(in_last), .dict_clear(dict_clear),
        .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        #1;
        out_ready = tog ? ~out_ready : 1'b1;
    end

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            rx_b.push_back(out_byte);
            rx_l.push_back(out_last);
        end
        if (err_overflow) n_err++;
        if (!in_ready) n_busy++;
        if (stalled && out_valid && out_byte != held) n_unstable++;
        stalled = out_valid && !out_ready;
        held    = out_byte;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_msg(input logic [1:0] tid);
        int guard;
        for (int i = 0; i < m_val.size(); i++) begin
            guard = 0;
            while (!in_ready && guard < 200) begin
                @(posedge clk);
                #1;
                guard++;
            end
            if (!in_ready) check("in_ready_timeout", 64'd0, 64'd1);
            in_valid = 1'b1;
            in_tid   = tid;
            in_value = m_val[i];
            in_copy  = m_copy[i];
            in_last  = (i == m_val.size() - 1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_msg(input string tag);
        int guard;
        guard = 0;
        while (rx_b.size() < exp_q.size() && guard < 300) begin
            @(posedge clk);
            #1;
            guard++;
        end
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_count"}, 64'(rx_b.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_b.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, i), 64'(rx_b[i]), 64'(exp_q[i]));
            check($sformatf("%s_last%0d", tag, i), 64'(rx_l[i]), 64'(i == exp_q.size() - 1));
        end
        rx_b.delete();
        rx_l.delete();
    endtask

    task automatic msg1_fields(input logic [63:0] v1);
        m_val  = '{64'd5, v1};
        m_copy = '{1'b0, 1'b1};
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_out_last"}, 64'(out_last), 64'd0);
        check({tag, "_out_byte"}, 64'(out_byte), 64'd0);
        check({tag, "_err"}, 64'(err_overflow), 64'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // 1: fresh dictionary
        n_busy = 0;
        msg1_fields(64'd300);
        send_msg(2'd2);
        exp_q = '{8'hE0, 8'h82, 8'h85, 8'h02, 8'hAC};
        expect_msg("t1");
        check("t1_in_ready_low_cycles", 64'(n_busy), 64'd5);

        // 2: repeat hits dictionary, then a changed value, then another template
        send_msg(2'd2);
        exp_q = '{8'hC0, 8'h82, 8'h85};
        expect_msg("t2a");
        msg1_fields(64'd301);
        send_msg(2'd2);
        exp_q = '{8'hE0, 8'h82, 8'h85, 8'h02, 8'hAD};
        expect_msg("t2b");
        msg1_fields(64'd300);
        send_msg(2'd1);
        exp_q = '{8'hE0, 8'h81, 8'h85, 8'h02, 8'hAC};
        expect_msg("t2c");

        // 4: backpressure toggling; dict[2][1] holds 301 so 300 is sent again
        n_unstable = 0;
        tog = 1'b1;
        send_msg(2'd2);
        exp_q = '{8'hE0, 8'h82, 8'h85, 8'h02, 8'hAC};
        expect_msg("t4");
        tog = 1'b0;
        check("t4_byte_stable", 64'(n_unstable), 64'd0);

        // 3: eight new COPY zeros spill pmap into a second byte
        m_val.delete();
        m_copy.delete();
        for (int i = 0; i < 8; i++) begin
            m_val.push_back(64'd0);
            m_copy.push_back(1'b1);
        end
        send_msg(2'd0);
        exp_q = '{8'h7F, 8'hE0, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
        expect_msg("t3");

        // 5: overflow beyond ten fields
        n_err = 0;
        m_val.delete();
        m_copy.delete();
        for (int i = 1; i <= 12; i++) begin
            m_val.push_back(64'(i));
            m_copy.push_back(1'b0);
        end
        send_msg(2'd0);
        exp_q = '{8'hC0, 8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87, 8'h88, 8'h89, 8'h8A};
        expect_msg("t5");
        check("t5_err_pulses", 64'(n_err), 64'd2);

        // 6: reset mid-emission, then dict_clear in IDLE
        msg1_fields(64'd300);
        send_msg(2'd2);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        rx_b.delete();
        rx_l.delete();
        check_reset_outputs("t6_midreset");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("t6_no_partial", 64'(rx_b.size()), 64'd0);
        send_msg(2'd2);
        exp_q = '{8'hE0, 8'h82, 8'h85, 8'h02, 8'hAC};
        expect_msg("t6a");
        dict_clear = 1'b1;
        @(posedge clk);
        #1;
        dict_clear = 1'b0;
        send_msg(2'd2);
        expect_msg("t6b");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
